data_memory_param: RTL and testbench

//  Parametrised single-port data memory for the CPU datapath with a valid/ready request port
//  and a registered, one-cycle-latency response. It adds hardware clear-on-reset via an

---
 rtl/data_memory_param.sv | 127 ++++++++++++
 tb/tb_data_memory_param.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_param.sv
// Parametrised single-port data memory with valid/ready request port,
// one-cycle registered response, clear-on-reset sweep and range checking.
module data_memory_param #(
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned ADDR_W         = 8,
    parameter int unsigned DEPTH          = 256,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              init_busy
);

    // Storage index width (at least one bit) and sweep pointer width.
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PTR_W = $clog2(DEPTH) + 1;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              r_state;
    logic [PTR_W-1:0]    r_clr_ptr;
    logic                r_req_ready;
    logic                r_init_busy;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic                r_rsp_err;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic                w_accept;
    logic                w_in_range;
    logic                w_clr_last;
    logic [IDX_W-1:0]    w_idx;
    logic [IDX_W-1:0]    w_clr_idx;

    // Request decode: accept handshake, range check without address wrap.
    assign w_accept   = req_valid & r_req_ready;
    assign w_in_range = (32'(req_addr) < DEPTH);
    assign w_idx      = IDX_W'(req_addr);
    assign w_clr_idx  = IDX_W'(r_clr_ptr);
    assign w_clr_last = (r_clr_ptr == PTR_W'(DEPTH - 1));

    // Init/run state machine with registered ready/busy flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clr_ptr <= '0;
            if (CLEAR_ON_RESET != 0) begin
                r_state     <= ST_INIT;
                r_req_ready <= 1'b0;
                r_init_busy <= 1'b1;
            end else begin
                r_state     <= ST_RUN;
                r_req_ready <= 1'b1;
                r_init_busy <= 1'b0;
            end
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_clr_ptr <= r_clr_ptr + PTR_W'(1);
                    if (w_clr_last) begin
                        r_state     <= ST_RUN;
                        r_req_ready <= 1'b1;
                        r_init_busy <= 1'b0;
                    end
                end
                ST_RUN: begin
                    r_state     <= ST_RUN;
                    r_req_ready <= 1'b1;
                    r_init_busy <= 1'b0;
                end
                default: begin
                    r_state     <= ST_RUN;
                    r_req_ready <= 1'b1;
                    r_init_busy <= 1'b0;
                end
            endcase
        end
    end

    // Storage update: sweep zeros during init, in-range writes during run; nothing under reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == ST_INIT) begin
                r_mem[w_clr_idx] <= '0;
            end else if (w_accept && req_write && w_in_range) begin
                r_mem[w_idx] <= req_wdata;
            end
        end
    end

    // Response register: read-first data, zero data with error flag when out of range.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= w_accept;
            if (w_accept) begin
                if (w_in_range) begin
                    r_rsp_rdata <= r_mem[w_idx];
                    r_rsp_err   <= 1'b0;
                end else begin
                    r_rsp_rdata <= '0;
                    r_rsp_err   <= 1'b1;
                end
            end
        end
    end

    assign req_ready = r_req_ready;
    assign init_busy = r_init_busy;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_data_memory_param.sv
// Bench for data_memory_param: three instances (default, DEPTH=200, no clear on reset),
// directed stimulus with an expected-response queue checked by a per-cycle monitor.
module tb_data_memory_param;

    localparam int NI = 3;

    logic       clk = 1'b1;
    logic       s_rst   [NI];
    logic       s_valid [NI];
    logic       s_write [NI];
    logic [7:0] s_addr  [NI];
    logic [7:0] s_wdata [NI];
    logic       o_ready [NI];
    logic       o_valid [NI];
    logic [7:0] o_rdata [NI];
    logic       o_err   [NI];
    logic       o_busy  [NI];

    typedef struct {
        int         inst;
        int         due;
        logic [7:0] rdata;
        logic       err;
        logic       dc;
    } exp_t;

    exp_t       sb [$];
    int         cyc      = 0;
    int         n_tests  = 0;
    int         n_failed = 0;
    logic       mon_en   = 1'b0;
    logic [7:0] hold_rdata [NI];
    logic       hold_err   [NI];
    logic       hold_known [NI];
    logic       clr_pend   [NI];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    data_memory_param u_dut_def (
        .clk(clk), .rst(s_rst[0]), .req_valid(s_valid[0]), .req_ready(o_ready[0]),
        .req_write(s_write[0]), .req_addr(s_addr[0]), .req_wdata(s_wdata[0]),
        .rsp_valid(o_valid[0]), .rsp_rdata(o_rdata[0]), .rsp_err(o_err[0]), .init_busy(o_busy[0])
    );

    data_memory_param #(.DEPTH(200)) u_dut_d200 (
        .clk(clk), .rst(s_rst[1]), .req_valid(s_valid[1]), .req_ready(o_ready[1]),
        .req_write(s_write[1]), .req_addr(s_addr[1]), .req_wdata(s_wdata[1]),
        .rsp_valid(o_valid[1]), .rsp_rdata(o_rdata[1]), .rsp_err(o_err[1]), .init_busy(o_busy[1])
    );

    data_memory_param #(.CLEAR_ON_RESET(0)) u_dut_nc (
        .clk(clk), .rst(s_rst[2]), .req_valid(s_valid[2]), .req_ready(o_ready[2]),
        .req_write(s_write[2]), .req_addr(s_addr[2]), .req_wdata(s_wdata[2]),
        .rsp_valid(o_valid[2]), .rsp_rdata(o_rdata[2]), .rsp_err(o_err[2]), .init_busy(o_busy[2])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge and return all request/reset lines to idle.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            s_rst[i]   = 1'b0;
            s_valid[i] = 1'b0;
            s_write[i] = 1'b0;
        end
    endtask

    // Drive one request for this cycle and queue the response it must produce next cycle.
    task automatic issue(input int i, input logic wr, input logic [7:0] a, input logic [7:0] d,
                         input logic [7:0] er, input logic ee, input logic dc);
        exp_t e;
        s_valid[i] = 1'b1;
        s_write[i] = wr;
        s_addr[i]  = a;
        s_wdata[i] = d;
        e.inst  = i;
        e.due   = cyc + 1;
        e.rdata = er;
        e.err   = ee;
        e.dc    = dc;
        sb.push_back(e);
    endtask

    // Count busy cycles (bounded) and require exactly the expected sweep length.
    task automatic wait_init(input int i, input int exp_cycles);
        int n;
        int low_n;
        n     = 0;
        low_n = 0;
        while (o_busy[i] === 1'b1 && n < 1000) begin
            if (o_ready[i] === 1'b0) low_n++;
            n++;
            tick();
        end
        check($sformatf("init_busy_cycles[%0d]", i), 32'(n), 32'(exp_cycles));
        check($sformatf("ready_low_cycles[%0d]", i), 32'(low_n), 32'(exp_cycles));
        check($sformatf("ready_after_init[%0d]", i), 32'(o_ready[i]), 32'd1);
    endtask

    // Per-cycle response monitor: valid exactly when due, payload matches, otherwise held.
    always @(negedge clk) begin
        int k;
        for (int i = 0; i < NI; i++) begin
            if (clr_pend[i] === 1'b1) begin
                hold_rdata[i] = 8'h00;
                hold_err[i]   = 1'b0;
                hold_known[i] = 1'b1;
                clr_pend[i]   = 1'b0;
            end
            if (mon_en) begin
                k = -1;
                for (int j = 0; j < sb.size(); j++) begin
                    if (sb[j].inst == i && sb[j].due <= cyc) k = j;
                end
                check($sformatf("rsp_valid[%0d]@%0d", i, cyc), 32'(o_valid[i]), 32'(k >= 0));
                if (k >= 0) begin
                    if (sb[k].due != cyc)
                        check($sformatf("rsp_late[%0d]", i), 32'(sb[k].due), 32'(cyc));
                    if (!sb[k].dc) begin
                        check($sformatf("rsp_rdata[%0d]@%0d", i, cyc), 32'(o_rdata[i]), 32'(sb[k].rdata));
                        check($sformatf("rsp_err[%0d]@%0d", i, cyc), 32'(o_err[i]), 32'(sb[k].err));
                        hold_rdata[i] = sb[k].rdata;
                        hold_err[i]   = sb[k].err;
                        hold_known[i] = 1'b1;
                    end else begin
                        hold_known[i] = 1'b0;
                    end
                    sb.delete(k);
                end else if (hold_known[i] === 1'b1) begin
                    check($sformatf("hold_rdata[%0d]@%0d", i, cyc), 32'(o_rdata[i]), 32'(hold_rdata[i]));
                    check($sformatf("hold_err[%0d]@%0d", i, cyc), 32'(o_err[i]), 32'(hold_err[i]));
                end
            end
            if (s_rst[i] === 1'b1) clr_pend[i] = 1'b1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < NI; i++) begin
            s_rst[i]      = 1'b1;
            s_valid[i]    = 1'b0;
            s_write[i]    = 1'b0;
            s_addr[i]     = 8'h00;
            s_wdata[i]    = 8'h00;
            hold_rdata[i] = 8'h00;
            hold_err[i]   = 1'b0;
            hold_known[i] = 1'b0;
            clr_pend[i]   = 1'b0;
        end
        tick();
        mon_en = 1'b1;

        // Reset state of the clearing and non-clearing instances.
        check("rst_busy_def", 32'(o_busy[0]), 32'd1);
        check("rst_ready_def", 32'(o_ready[0]), 32'd0);
        check("rst_ready_nc", 32'(o_ready[2]), 32'd1);
        check("rst_busy_nc", 32'(o_busy[2]), 32'd0);

        // 1: sweep length, then a cleared word reads back zero.
        wait_init(0, 256);
        issue(0, 1'b0, 8'h10, 8'h00, 8'h00, 1'b0, 1'b0); tick();
        tick();

        // 2: write, idle, read back.
        issue(0, 1'b1, 8'h10, 8'hAA, 8'h00, 1'b0, 1'b0); tick();
        tick();
        issue(0, 1'b0, 8'h10, 8'h00, 8'hAA, 1'b0, 1'b0); tick();
        tick();

        // 3: back-to-back write/write/read to one word.
        issue(0, 1'b1, 8'h30, 8'h55, 8'h00, 1'b0, 1'b0); tick();
        issue(0, 1'b1, 8'h30, 8'h66, 8'h55, 1'b0, 1'b0); tick();
        issue(0, 1'b0, 8'h30, 8'h00, 8'h66, 1'b0, 1'b0); tick();
        // Top word of the full-depth instance.
        issue(0, 1'b1, 8'hFF, 8'h3C, 8'h00, 1'b0, 1'b0); tick();
        issue(0, 1'b0, 8'hFF, 8'h00, 8'h3C, 1'b0, 1'b0); tick();
        tick();

        // 4: DEPTH=200 range handling and the last valid word.
        check("ready_d200", 32'(o_ready[1]), 32'd1);
        issue(1, 1'b1, 8'hC8, 8'h77, 8'h00, 1'b1, 1'b0); tick();
        issue(1, 1'b0, 8'hC8, 8'h00, 8'h00, 1'b1, 1'b0); tick();
        issue(1, 1'b0, 8'h48, 8'h00, 8'h00, 1'b0, 1'b0); tick();
        issue(1, 1'b1, 8'hC7, 8'h12, 8'h00, 1'b0, 1'b0); tick();
        issue(1, 1'b0, 8'hC7, 8'h00, 8'h12, 1'b0, 1'b0); tick();
        issue(1, 1'b1, 8'hFF, 8'h99, 8'h00, 1'b1, 1'b0); tick();
        issue(1, 1'b0, 8'h08, 8'h00, 8'h00, 1'b0, 1'b0); tick();
        tick();

        // 5: read accepted in the reset cycle is dropped; sweep reruns; ignored requests in INIT.
        s_rst[0]   = 1'b1;
        s_valid[0] = 1'b1;
        s_write[0] = 1'b0;
        s_addr[0]  = 8'h10;
        tick();
        check("rerun_busy", 32'(o_busy[0]), 32'd1);
        check("rerun_ready", 32'(o_ready[0]), 32'd0);
        s_valid[0] = 1'b1;
        s_write[0] = 1'b1;
        s_addr[0]  = 8'h20;
        s_wdata[0] = 8'h99;
        tick();
        s_valid[0] = 1'b1;
        s_write[0] = 1'b0;
        tick();
        wait_init(0, 254);
        issue(0, 1'b0, 8'h10, 8'h00, 8'h00, 1'b0, 1'b0); tick();
        issue(0, 1'b0, 8'h30, 8'h00, 8'h00, 1'b0, 1'b0); tick();
        tick();

        // 6: contents survive reset without the clear sweep.
        issue(2, 1'b1, 8'h11, 8'hBB, 8'h00, 1'b0, 1'b1); tick();
        s_rst[2] = 1'b1;
        tick();
        check("nc_ready_after_rst", 32'(o_ready[2]), 32'd1);
        check("nc_busy_after_rst", 32'(o_busy[2]), 32'd0);
        issue(2, 1'b0, 8'h11, 8'h00, 8'hBB, 1'b0, 1'b0); tick();
        tick();
        tick();

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
